// File: rtl/repetition_matcher.sv
// Multi-channel matcher for SVA-style consecutive, goto and nonconsecutive repetition.
// Optional abort timer for armed channels is enabled by defining REP_TIMEOUT_EN.
module repetition_matcher #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned MAX_N   = 15,
  parameter int unsigned CNT_W   = $clog2(MAX_N + 1),
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_n,
  input  logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] ev,
  output logic [NUM_CH-1:0] match,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] ovf,
  output logic [NUM_CH-1:0] timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HIT   = 2'd2
  } state_e;

  localparam logic [1:0] MODE_GOTO = 2'd1;
  localparam logic [1:0] MODE_NONC = 2'd2;

  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  n_q;
  logic              cfg_chg_c;
  logic              goto_c;
  logic              nonc_c;
  logic [CNT_W-1:0]  last_c;
  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] ev_last_c;
  logic [NUM_CH-1:0] match_c;
  logic [NUM_CH-1:0] busy_c;
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] ovf_d;

`ifdef REP_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0]  tmr_q [NUM_CH];
  logic [TMR_W-1:0]  tmr_d [NUM_CH];
  logic [NUM_CH-1:0] to_q;
  logic [NUM_CH-1:0] to_d;
`endif

  assign cfg_chg_c = (cfg_mode != mode_q) || (cfg_n != n_q);
  assign goto_c    = (cfg_mode == MODE_GOTO);
  assign nonc_c    = (cfg_mode == MODE_NONC);

  // Effective N-1: zero means one, oversize values clamp to MAX_N.
  always_comb begin
    if (cfg_n == '0) begin
      last_c = '0;
    end else if (cfg_n > CNT_W'(MAX_N)) begin
      last_c = CNT_W'(MAX_N - 1);
    end else begin
      last_c = cfg_n - CNT_W'(1);
    end
  end

  // Per-channel next state, counter and output decode.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      ev_last_c[i] = ev[i] && (cnt_q[i] == last_c);
      match_c[i]   = 1'b0;
      busy_c[i]    = 1'b0;
      ovf_d[i]     = 1'b0;
`ifdef REP_TIMEOUT_EN
      tmr_d[i]     = tmr_q[i];
      to_d[i]      = 1'b0;
`endif
      if (!goto_c && !nonc_c) begin
        state_d[i] = S_IDLE;
        busy_c[i]  = (cnt_q[i] != '0);
        match_c[i] = ev_last_c[i];
        if (ev_last_c[i]) begin
          cnt_d[i] = '0;
        end else if (ev[i]) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else begin
          cnt_d[i] = '0;
        end
      end else begin
        busy_c[i] = (state_q[i] != S_IDLE);
        case (state_q[i])
          S_IDLE: begin
            if (trig[i]) begin
              state_d[i] = S_ARMED;
              cnt_d[i]   = '0;
`ifdef REP_TIMEOUT_EN
              tmr_d[i]   = '0;
`endif
            end
          end
          S_ARMED: begin
`ifdef REP_TIMEOUT_EN
            tmr_d[i] = tmr_q[i] + TMR_W'(1);
`endif
            if (trig[i]) begin
              cnt_d[i] = '0;
`ifdef REP_TIMEOUT_EN
              tmr_d[i] = '0;
`endif
            end else if (ev_last_c[i]) begin
              cnt_d[i] = '0;
              if (nonc_c) begin
                state_d[i] = S_HIT;
              end else begin
                state_d[i] = S_IDLE;
                match_c[i] = 1'b1;
              end
            end else begin
              if (ev[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
`ifdef REP_TIMEOUT_EN
              if (tmr_q[i] == TMR_W'(TIMEOUT - 1)) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = '0;
                to_d[i]    = 1'b1;
              end
`endif
            end
          end
          S_HIT: begin
            match_c[i] = 1'b1;
            if (trig[i]) begin
              state_d[i] = S_ARMED;
              cnt_d[i]   = '0;
`ifdef REP_TIMEOUT_EN
              tmr_d[i]   = '0;
`endif
            end else if (ev[i]) begin
              state_d[i] = S_IDLE;
              ovf_d[i]   = 1'b1;
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
      // A configuration change flushes every channel and suppresses this cycle's outputs.
      if (cfg_chg_c) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
        match_c[i] = 1'b0;
        ovf_d[i]   = 1'b0;
`ifdef REP_TIMEOUT_EN
        to_d[i]    = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= cfg_mode;
    n_q    <= cfg_n;
    if (rst) begin
      ovf_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef REP_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        tmr_q[i] <= '0;
      end
    end else begin
      to_q <= to_d;
      for (int i = 0; i < NUM_CH; i++) begin
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  assign timeout = to_q;
`else
  // Without the timer an armed channel waits indefinitely.
  if (TIMEOUT > 0) begin : g_no_timer
    assign timeout = '0;
  end else begin : g_no_timer_zero
    assign timeout = '0;
  end
`endif

  assign match = match_c;
  assign busy  = busy_c;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_repetition_matcher.sv
// Directed bench for repetition_matcher: per-cycle expectations queued and checked at negedge.
module tb_repetition_matcher;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned MAX_N   = 15;
  localparam int unsigned CNT_W   = $clog2(MAX_N + 1);
  localparam int unsigned TIMEOUT = 8;
`ifdef REP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_n;
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] timeout;

  typedef struct {
    logic [3:0] m;
    logic [3:0] b;
    logic [3:0] o;
    logic [3:0] t;
    string      tag;
  } exp_t;

  exp_t             sb[$];
  int               n_assert = 0;
  int               n_fail   = 0;
  logic [1:0]       mode_v;
  logic [CNT_W-1:0] n_v;

  repetition_matcher #(
    .NUM_CH (NUM_CH),
    .MAX_N  (MAX_N),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg_mode(cfg_mode),
    .cfg_n   (cfg_n),
    .trig    (trig),
    .ev      (ev),
    .match   (match),
    .busy    (busy),
    .ovf     (ovf),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] expv);
    n_assert++;
    assert (act === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, act, expv);
    end
  endtask

  // One clock cycle: drive after posedge, queue the expectation, check at negedge.
  task automatic step(input logic r, input logic [3:0] t, input logic [3:0] e,
                      input logic [3:0] m, input logic [3:0] b, input logic [3:0] o,
                      input logic [3:0] to, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    rst      = r;
    cfg_mode = mode_v;
    cfg_n    = n_v;
    trig     = t;
    ev       = e;
    sb.push_back('{m, b, o, to, tag});
    @(negedge clk);
    x = sb.pop_front();
    chk({x.tag, ".match"},   match,   x.m);
    chk({x.tag, ".busy"},    busy,    x.b);
    chk({x.tag, ".ovf"},     ovf,     x.o);
    chk({x.tag, ".timeout"}, timeout, x.t);
  endtask

  initial begin
    rst      = 1'b1;
    mode_v   = 2'd0;
    n_v      = CNT_W'(5);
    cfg_mode = mode_v;
    cfg_n    = n_v;
    trig     = '0;
    ev       = '0;

    step(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "rst_hold");
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "rst_after");

    // CONSEC N=5: a 12-cycle run on ch0 matches on cycles 5 and 10 only.
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 4'h0, 4'b0001,
           (k == 5 || k == 10) ? 4'b0001 : 4'b0000,
           (k == 1 || k == 6 || k == 11) ? 4'b0000 : 4'b0001,
           4'h0, 4'h0, $sformatf("consec_c%0d", k));
    end
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'b0001, 4'h0, 4'h0, "consec_tail0");
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0,    4'h0, 4'h0, "consec_tail1");

    // CONSEC N=1 on two channels, then N=0 treated as 1.
    n_v = CNT_W'(1);
    step(1'b0, 4'h0, 4'h0,    4'h0,    4'h0, 4'h0, 4'h0, "n1_chg");
    step(1'b0, 4'h0, 4'b1010, 4'b1010, 4'h0, 4'h0, 4'h0, "n1_ev");
    n_v = CNT_W'(0);
    step(1'b0, 4'h0, 4'h0,    4'h0,    4'h0, 4'h0, 4'h0, "n0_chg");
    step(1'b0, 4'h0, 4'b0101, 4'b0101, 4'h0, 4'h0, 4'h0, "n0_ev");

    // Reserved mode behaves as CONSEC, and trig is ignored there.
    mode_v = 2'd3;
    n_v    = CNT_W'(2);
    step(1'b0, 4'h0,    4'h0,    4'h0,    4'h0,    4'h0, 4'h0, "rsv_chg");
    step(1'b0, 4'b0001, 4'b0001, 4'h0,    4'h0,    4'h0, 4'h0, "rsv_ev0");
    step(1'b0, 4'h0,    4'b0001, 4'b0001, 4'b0001, 4'h0, 4'h0, "rsv_ev1");

    // GOTO N=2 on ch1: ev in trig cycle ignored, match at t6.
    mode_v = 2'd1;
    n_v    = CNT_W'(2);
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "goto_chg");
    for (int t = 0; t <= 7; t++) begin
      step(1'b0,
           (t == 0) ? 4'b0010 : 4'b0000,
           (t == 0 || t == 3 || t == 6) ? 4'b0010 : 4'b0000,
           (t == 6) ? 4'b0010 : 4'b0000,
           (t >= 1 && t <= 6) ? 4'b0010 : 4'b0000,
           4'h0, 4'h0, $sformatf("goto_t%0d", t));
    end

    // GOTO restart, N=1, ch3.
    n_v = CNT_W'(1);
    step(1'b0, 4'h0,    4'h0,    4'h0,    4'h0,    4'h0, 4'h0, "rst_chg");
    step(1'b0, 4'b1000, 4'h0,    4'h0,    4'h0,    4'h0, 4'h0, "restart_t0");
    step(1'b0, 4'h0,    4'h0,    4'h0,    4'b1000, 4'h0, 4'h0, "restart_t1");
    step(1'b0, 4'b1000, 4'b1000, 4'h0,    4'b1000, 4'h0, 4'h0, "restart_t2");
    step(1'b0, 4'h0,    4'h0,    4'h0,    4'b1000, 4'h0, 4'h0, "restart_t3");
    step(1'b0, 4'h0,    4'b1000, 4'b1000, 4'b1000, 4'h0, 4'h0, "restart_t4");
    step(1'b0, 4'h0,    4'h0,    4'h0,    4'h0,    4'h0, 4'h0, "restart_t5");

    // NONCONSEC N=2 on ch2: HIT level, overflow on extra ev.
    mode_v = 2'd2;
    n_v    = CNT_W'(2);
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "nc_chg");
    for (int t = 0; t <= 9; t++) begin
      step(1'b0,
           (t == 0) ? 4'b0100 : 4'b0000,
           (t == 2 || t == 4 || t == 7) ? 4'b0100 : 4'b0000,
           (t >= 5 && t <= 7) ? 4'b0100 : 4'b0000,
           (t >= 1 && t <= 7) ? 4'b0100 : 4'b0000,
           (t == 8) ? 4'b0100 : 4'b0000,
           4'h0, $sformatf("nc_t%0d", t));
    end
    // trig with ev in HIT restarts without overflow.
    step(1'b0, 4'b0100, 4'h0,    4'h0,    4'h0,    4'h0, 4'h0, "nc_u0");
    step(1'b0, 4'h0,    4'b0100, 4'h0,    4'b0100, 4'h0, 4'h0, "nc_u1");
    step(1'b0, 4'h0,    4'b0100, 4'h0,    4'b0100, 4'h0, 4'h0, "nc_u2");
    step(1'b0, 4'h0,    4'h0,    4'b0100, 4'b0100, 4'h0, 4'h0, "nc_u3");
    step(1'b0, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'h0, 4'h0, "nc_u4");
    step(1'b0, 4'h0,    4'h0,    4'h0,    4'b0100, 4'h0, 4'h0, "nc_u5");

    // Config change flushes armed channels (ch2 still armed from above).
    mode_v = 2'd1;
    n_v    = CNT_W'(3);
    step(1'b0, 4'h0,    4'h0,    4'h0, 4'b0100, 4'h0, 4'h0, "cfg_chg0");
    step(1'b0, 4'b0001, 4'h0,    4'h0, 4'h0,    4'h0, 4'h0, "cfg_c0");
    step(1'b0, 4'h0,    4'b0001, 4'h0, 4'b0001, 4'h0, 4'h0, "cfg_c1");
    n_v = CNT_W'(4);
    step(1'b0, 4'h0,    4'h0,    4'h0, 4'b0001, 4'h0, 4'h0, "cfg_c2");
    step(1'b0, 4'h0,    4'h0,    4'h0, 4'h0,    4'h0, 4'h0, "cfg_c3");
    step(1'b0, 4'h0,    4'b0001, 4'h0, 4'h0,    4'h0, 4'h0, "cfg_c4");
    // Change cycle suppresses a match the new N would otherwise give.
    n_v = CNT_W'(3);
    step(1'b0, 4'h0,    4'h0,    4'h0, 4'h0,    4'h0, 4'h0, "cfg_d_chg");
    step(1'b0, 4'b0001, 4'h0,    4'h0, 4'h0,    4'h0, 4'h0, "cfg_d0");
    step(1'b0, 4'h0,    4'b0001, 4'h0, 4'b0001, 4'h0, 4'h0, "cfg_d1");
    n_v = CNT_W'(2);
    step(1'b0, 4'h0,    4'b0001, 4'h0, 4'b0001, 4'h0, 4'h0, "cfg_d2");
    step(1'b0, 4'h0,    4'h0,    4'h0, 4'h0,    4'h0, 4'h0, "cfg_d3");

    // Reset asserted while ch0 is in HIT.
    mode_v = 2'd2;
    n_v    = CNT_W'(1);
    step(1'b0, 4'h0,    4'h0,    4'h0,    4'h0,    4'h0, 4'h0, "hit_chg");
    step(1'b0, 4'b0001, 4'h0,    4'h0,    4'h0,    4'h0, 4'h0, "hit_h0");
    step(1'b0, 4'h0,    4'b0001, 4'h0,    4'b0001, 4'h0, 4'h0, "hit_h1");
    step(1'b0, 4'h0,    4'h0,    4'b0001, 4'b0001, 4'h0, 4'h0, "hit_h2");
    step(1'b1, 4'h0,    4'h0,    4'b0001, 4'b0001, 4'h0, 4'h0, "hit_rst");
    step(1'b0, 4'h0,    4'h0,    4'h0,    4'h0,    4'h0, 4'h0, "hit_after");

    // Armed-channel abort window (only fires when the timer is built in).
    mode_v = 2'd1;
    n_v    = CNT_W'(2);
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "to_chg");
    for (int t = 0; t <= 10; t++) begin
      step(1'b0,
           (t == 0) ? 4'b0001 : 4'b0000,
           4'h0, 4'h0,
           (t == 0) ? 4'b0000 : ((t >= 9 && TO_EN) ? 4'b0000 : 4'b0001),
           4'h0,
           (t == 9 && TO_EN) ? 4'b0001 : 4'b0000,
           $sformatf("to_a%0d", t));
    end
    // Match on the expiry cycle wins over timeout.
    for (int t = 0; t <= 9; t++) begin
      step(1'b0,
           (t == 0) ? 4'b0001 : 4'b0000,
           (t == 3 || t == 8) ? 4'b0001 : 4'b0000,
           (t == 8) ? 4'b0001 : 4'b0000,
           (t == 0) ? (TO_EN ? 4'b0000 : 4'b0001) : ((t <= 8) ? 4'b0001 : 4'b0000),
           4'h0, 4'h0, $sformatf("to_b%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
